// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//   Shares one LSB-first word serializer between NUM_REQ requesters using
//   round-robin arbitration. A granted word is latched onto ser_number. One
//   cycle later a single-cycle ser_enable start pulse is issued. The block
//   then waits out the serializer busy window and an optional inter-frame
//   gap before it returns to idle.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   req        : per-requester request, bit i = requester i
//   data       : flat word bus, requester i at [i*DATA_W +: DATA_W]
//   ack        : one-cycle pulse, word of requester i latched
//   done       : one-cycle pulse, requester i's frame fully shifted
//   ser_number : word presented to the serializer, held until next grant
//   ser_enable : one-cycle start pulse to the serializer
//   busy       : high whenever the FSM is not idle
//   grant_id   : index of the current or most recent grant
module serial_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 32,
    parameter int SHIFT_CYCLES = 33,
    parameter int GAP_CYCLES   = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  data,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NUM_REQ-1:0]         done,
    output logic [DATA_W-1:0]          ser_number,
    output logic                       ser_enable,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int GW      = $clog2(NUM_REQ);
    localparam int CNT_MAX = (SHIFT_CYCLES > GAP_CYCLES) ? SHIFT_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2,
        GAP  = 2'd3
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [GW-1:0]       last_grant, last_nx;
    logic [NUM_REQ-1:0]  ack_nx, done_nx;
    logic [DATA_W-1:0]   num_nx;
    logic                ser_en_nx, busy_nx;
    logic [GW-1:0]       gid_nx;

    // Round-robin search: candidates last_grant+1, +2, ... wrapping at
    // NUM_REQ. The sum is one bit wider so a single subtraction wraps it.
    logic [GW:0]         rr_sum;
    logic [GW-1:0]       rr_idx;
    logic                win_found;
    logic [GW-1:0]       win_id;
    logic [DATA_W-1:0]   win_data;

    always_comb begin
        rr_sum    = '0;
        rr_idx    = '0;
        win_found = 1'b0;
        win_id    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_sum = {1'b0, last_grant} + (GW+1)'(k);
            if (rr_sum >= (GW+1)'(NUM_REQ)) begin
                rr_sum = rr_sum - (GW+1)'(NUM_REQ);
            end
            rr_idx = rr_sum[GW-1:0];
            if (!win_found && req[rr_idx]) begin
                win_found = 1'b1;
                win_id    = rr_idx;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == GW'(i)) begin
                win_data = data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        last_nx   = last_grant;
        ack_nx    = ack;
        done_nx   = done;
        num_nx    = ser_number;
        ser_en_nx = ser_enable;
        busy_nx   = busy;
        gid_nx    = grant_id;
        case (state)
            IDLE: begin
                ack_nx    = '0;
                done_nx   = '0;
                ser_en_nx = 1'b0;
                if (win_found) begin
                    ack_nx   = NUM_REQ'(1) << win_id;
                    num_nx   = win_data;
                    gid_nx   = win_id;
                    last_nx  = win_id;
                    busy_nx  = 1'b1;
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                // ser_number was loaded one cycle earlier, so it is already
                // stable when the serializer sees the start pulse.
                ack_nx    = '0;
                ser_en_nx = 1'b1;
                cnt_nx    = '0;
                state_nx  = SEND;
            end
            SEND: begin
                ser_en_nx = 1'b0;
                if (cnt == CNT_W'(SHIFT_CYCLES - 1)) begin
                    done_nx = NUM_REQ'(1) << grant_id;
                    cnt_nx  = '0;
                    if (GAP_CYCLES > 0) begin
                        state_nx = GAP;
                    end else begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                    end
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                done_nx = '0;
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end
        endcase
    end

    // Reset clears everything at once, which abandons any frame in flight
    // without a done pulse and restores requester 0 as first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= GW'(NUM_REQ - 1);
            ack        <= '0;
            done       <= '0;
            ser_number <= '0;
            ser_enable <= 1'b0;
            busy       <= 1'b0;
            grant_id   <= '0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            last_grant <= last_nx;
            ack        <= ack_nx;
            done       <= done_nx;
            ser_number <= num_nx;
            ser_enable <= ser_en_nx;
            busy       <= busy_nx;
            grant_id   <= gid_nx;
        end
    end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// tb_serial_tx_arbiter
//   Directed bench for serial_tx_arbiter. Instance u_dut uses the default
//   parameters; instance u_dut_ng is built with GAP_CYCLES=0. Inputs change
//   1ns after a rising edge and outputs are sampled at the same point.
module tb_serial_tx_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int SC = 33;
    localparam int GC = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR-1:0]    req, ack, done;
    logic [NR*DW-1:0] data;
    logic [DW-1:0]    ser_number;
    logic             ser_enable, busy;
    logic [1:0]       grant_id;

    logic [NR-1:0]    req_b, ack_b, done_b;
    logic [NR*DW-1:0] data_b;
    logic [DW-1:0]    ser_number_b;
    logic             ser_enable_b, busy_b;
    logic [1:0]       grant_id_b;

    serial_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .SHIFT_CYCLES(SC), .GAP_CYCLES(GC)) u_dut (
        .clk(clk), .reset(reset), .req(req), .data(data), .ack(ack), .done(done),
        .ser_number(ser_number), .ser_enable(ser_enable), .busy(busy), .grant_id(grant_id)
    );

    serial_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .SHIFT_CYCLES(SC), .GAP_CYCLES(0)) u_dut_ng (
        .clk(clk), .reset(reset), .req(req_b), .data(data_b), .ack(ack_b), .done(done_b),
        .ser_number(ser_number_b), .ser_enable(ser_enable_b), .busy(busy_b), .grant_id(grant_id_b)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin tick(); n++; end while (ack == '0 && n < 200);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin tick(); n++; end while (done == '0 && n < 200);
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin tick(); n++; end while (busy != 1'b0 && n < 200);
    endtask

    // Called when ack has just become visible; walks the frame to idle.
    task automatic frame_chk(input int id, input logic [DW-1:0] word);
        int n;
        logic held;
        chk($sformatf("ack_id%0d", id), 64'(ack), 64'(1 << id));
        chk($sformatf("gid_id%0d", id), 64'(grant_id), 64'(id));
        chk($sformatf("num_at_ack_id%0d", id), 64'(ser_number), 64'(word));
        chk("busy_at_ack", 64'(busy), 64'd1);
        chk("sen_low_at_ack", 64'(ser_enable), 64'd0);
        tick();
        chk("sen_pulse", 64'(ser_enable), 64'd1);
        chk("ack_clear", 64'(ack), 64'd0);
        chk("num_at_sen", 64'(ser_number), 64'(word));
        n = 0;
        held = 1'b1;
        do begin
            tick(); n++;
            if (ser_number !== word || ser_enable !== 1'b0) held = 1'b0;
        end while (done == '0 && n < 200);
        chk("num_stable_sen_once", 64'(held), 64'd1);
        chk("done_latency", 64'(n), 64'(SC));
        chk($sformatf("done_id%0d", id), 64'(done), 64'(1 << id));
        wait_idle(n);
        chk("busy_drop_after_done", 64'(n), 64'(GC));
        chk("done_clear", 64'(done), 64'd0);
    endtask

    initial begin
        int n, t_last;
        logic early;
        reset  = 1'b1;
        req    = '0;
        data   = '0;
        req_b  = '0;
        data_b = '0;

        // Reset then idle
        repeat (3) tick();
        chk("rst_gid", 64'(grant_id), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        reset = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_ack", 64'(ack), 64'd0);
            chk("idle_sen", 64'(ser_enable), 64'd0);
            chk("idle_num", 64'(ser_number), 64'd0);
        end

        // Single request
        req = 4'b0001;
        data[0 +: DW] = 32'hA5A5_0F0F;
        tick();
        chk("single_ack_next_cycle", 64'(ack), 64'h1);
        req = '0;
        frame_chk(0, 32'hA5A5_0F0F);

        // Round-robin, priority restarted by reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < NR; i++) data[i*DW +: DW] = 32'h1000_0000 + i;
        t_last = 0;
        for (int k = 0; k < 5; k++) begin
            wait_ack(n);
            if (k > 0) chk("rr_spacing", 64'(cyc - t_last), 64'(SC + GC + 2));
            t_last = cyc;
            if (k == 4) req = '0;
            frame_chk(k % NR, 32'h1000_0000 + (k % NR));
        end

        // Priority wrap: serve 2, then 0101 goes to 0 then 2
        req = 4'b0100;
        data[2*DW +: DW] = 32'h2222_2222;
        wait_ack(n);
        req = '0;
        frame_chk(2, 32'h2222_2222);
        req = 4'b0101;
        data[0 +: DW] = 32'h0A0A_0A0A;
        data[2*DW +: DW] = 32'h2C2C_2C2C;
        wait_ack(n);
        req = 4'b0100;
        frame_chk(0, 32'h0A0A_0A0A);
        wait_ack(n);
        chk("wrap_second_immediate", 64'(n), 64'd1);
        req = '0;
        frame_chk(2, 32'h2C2C_2C2C);

        // Late request arriving during SEND
        req = 4'b0001;
        data[0 +: DW] = 32'h0000_BEEF;
        wait_ack(n);
        chk("late_first_ack", 64'(ack), 64'h1);
        req = '0;
        repeat (11) tick();
        req = 4'b0010;
        data[DW +: DW] = 32'h1234_5678;
        n = 0;
        early = 1'b0;
        do begin
            tick(); n++;
            if (ack != '0) early = 1'b1;
        end while (done == '0 && n < 200);
        chk("late_no_early_ack", 64'(early), 64'd0);
        chk("late_done0", 64'(done), 64'h1);
        wait_ack(n);
        chk("late_ack_after_done", 64'(n), 64'(GC + 1));
        req = '0;
        frame_chk(1, 32'h1234_5678);

        // Reset mid-frame
        req = 4'b0001;
        data[0 +: DW] = 32'hDEAD_0001;
        wait_ack(n);
        req = '0;
        tick();
        chk("mid_sen", 64'(ser_enable), 64'd1);
        repeat (10) tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_ack", 64'(ack), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_sen", 64'(ser_enable), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_num", 64'(ser_number), 64'd0);
        chk("mid_rst_gid", 64'(grant_id), 64'd0);
        repeat (2) tick();
        req = 4'b0010;
        data[DW +: DW] = 32'hC0DE_0002;
        reset = 1'b0;
        wait_ack(n);
        chk("post_rst_ack_latency", 64'(n), 64'd1);
        req = '0;
        frame_chk(1, 32'hC0DE_0002);

        // GAP_CYCLES=0 build
        req_b = 4'b0011;
        data_b[0 +: DW] = 32'hB0B0_0000;
        data_b[DW +: DW] = 32'hB1B1_1111;
        tick();
        chk("ng_ack0", 64'(ack_b), 64'h1);
        chk("ng_num0", 64'(ser_number_b), 64'hB0B0_0000);
        n = 0;
        do begin tick(); n++; end while (done_b == '0 && n < 200);
        chk("ng_done_latency", 64'(n), 64'(SC + 1));
        chk("ng_done0", 64'(done_b), 64'h1);
        chk("ng_busy_low_at_done", 64'(busy_b), 64'd0);
        tick();
        chk("ng_ack1_next", 64'(ack_b), 64'h2);
        chk("ng_num1", 64'(ser_number_b), 64'hB1B1_1111);
        chk("ng_gid1", 64'(grant_id_b), 64'd1);
        chk("ng_done_clear", 64'(done_b), 64'd0);
        req_b = '0;
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
